// File: rtl/pin_bus_pkg.sv
// Shared types and ui_in bit positions for the pin-level register bus responder.
package pin_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    ACK,
    WAIT_LOW
  } state_t;

  localparam int REQ_BIT  = 0;
  localparam int RW_BIT   = 1;
  localparam int ADDR_LSB = 2;
  localparam int ADDR_W   = 4;
  localparam int PAR_BIT  = 6;

  localparam logic [7:0] OE_DRIVE = 8'hFF;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchronizer for a single asynchronous pin; clears on reset.
module pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pin_bus_responder.sv
// Four-phase req/ack responder decoding pin transactions into byte register reads/writes.
// Optional write parity checking is enabled by defining PIN_BUS_PARITY_EN.
module pin_bus_responder
  import pin_bus_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            ui_in,
  input  logic [7:0]            uio_in,
  output logic [7:0]            uio_out,
  output logic [7:0]            uio_oe,
  output logic [7:0]            uo_out,
  output logic [NUM_REGS*8-1:0] regs_o
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

  state_t            state;
  logic              req_pin;
  logic              rw_pin;
  logic              par_pin;
  logic [ADDR_W-1:0] addr_pin;
  logic              req_s;
  logic              req_prev;
  logic [FILL_W-1:0] fill_cnt;
  logic              armed;
  logic              req_rise;
  logic              par_bad;
  logic              unused_pins;
  logic [7:0]        rd_val;
  logic [7:0]        rdata;
  logic              rw_q;
  logic              err_pend;
  logic              ack_q;
  logic              err_q;
  logic [7:0]        regs [NUM_REGS];

  assign req_pin  = ui_in[REQ_BIT];
  assign rw_pin   = ui_in[RW_BIT];
  assign par_pin  = ui_in[PAR_BIT];
  assign addr_pin = ui_in[ADDR_LSB +: ADDR_W];

`ifdef PIN_BUS_PARITY_EN
  assign par_bad     = ^{uio_in, par_pin};
  assign unused_pins = ui_in[7];
`else
  assign par_bad     = 1'b0;
  assign unused_pins = &{ui_in[7], par_pin};
`endif

  pin_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_pin),
    .q   (req_s)
  );

  // Until the chain has refilled after reset, req_s does not reflect the pin,
  // so edges are only trusted once the pin has genuinely been seen low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_prev <= 1'b0;
      fill_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      req_prev <= req_s;
      if (fill_cnt != FILL_DONE) begin
        fill_cnt <= fill_cnt + FILL_W'(1);
      end else if (!req_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign req_rise = armed & req_s & ~req_prev;

  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_pin == i[ADDR_W-1:0]) begin
        rd_val = regs[i];
      end
    end
  end

  // The capture/commit happens on the edge that enters LATCH so the register
  // file updates one cycle ahead of ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rw_q     <= 1'b0;
      err_pend <= 1'b0;
      rdata    <= 8'h00;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      uio_out  <= 8'h00;
      uio_oe   <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_rise) begin
            rw_q     <= rw_pin;
            err_pend <= !rw_pin && par_bad;
            rdata    <= rw_pin ? rd_val : 8'h00;
            if (!rw_pin && !par_bad) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_pin == i[ADDR_W-1:0]) begin
                  regs[i] <= uio_in;
                end
              end
            end
            state <= LATCH;
          end
        end
        LATCH: begin
          ack_q <= 1'b1;
          err_q <= err_pend;
          if (rw_q) begin
            uio_out <= rdata;
            uio_oe  <= OE_DRIVE;
          end
          state <= ACK;
        end
        ACK: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            uio_out <= 8'h00;
            uio_oe  <= 8'h00;
            state   <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*8 +: 8] = regs[g];
  end

  assign uo_out = {6'b000000, err_q, ack_q};

endmodule

// File: tb/tb_pin_bus_responder.sv
// Self-checking bench for pin_bus_responder: table vectors, random traffic vs a register model,
// and hand sequences for reset, short pulses and parity (when PIN_BUS_PARITY_EN is defined).
module tb_pin_bus_responder;

  localparam int NREGS = 8;
  localparam int SYNC  = 2;
  localparam int BOUND = 30;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       ui_in;
  logic [7:0]       uio_in;
  logic [7:0]       uio_out;
  logic [7:0]       uio_oe;
  logic [7:0]       uo_out;
  logic [NREGS*8-1:0] regs_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [16];

  int          obs_lat;
  int          obs_rel;
  logic [7:0]  obs_rd;
  logic [7:0]  obs_oe;
  logic        obs_err;
  logic [5:0]  obs_hi;
  logic [63:0] obs_pre;
  logic [7:0]  obs_oe_after;
  logic [7:0]  obs_out_after;

  typedef struct {
    logic       rw;
    logic [3:0] addr;
    logic [7:0] data;
    logic       par;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vecs [8];

  pin_bus_responder #(.NUM_REGS(NREGS), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out),
    .regs_o  (regs_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] modelRegs();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++) r[i*8 +: 8] = mem[i];
    return r;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic modelTxn(input logic rw, input logic [3:0] addr, input logic [7:0] data,
                          input logic par, output logic [7:0] exp_rd, output logic exp_err);
    logic perr;
    perr = 1'b0;
`ifdef PIN_BUS_PARITY_EN
    perr = ^{data, par};
`endif
    exp_err = !rw && perr;
    exp_rd  = 8'h00;
    if (rw) begin
      if (int'(addr) < NREGS) exp_rd = mem[addr];
    end else if (int'(addr) < NREGS && !perr) begin
      mem[addr] = data;
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [3:0] addr, input logic [7:0] data,
                               input logic par);
    @(negedge clk);
    uio_in  = data;
    ui_in   = {1'b0, par, addr, rw, 1'b1};
    obs_lat = 0;
    obs_pre = 64'(regs_o);
    do begin
      @(negedge clk);
      obs_lat++;
      if (!uo_out[0]) obs_pre = 64'(regs_o);
    end while (!uo_out[0] && obs_lat < BOUND);
    if (!uo_out[0]) obs_lat = -1;
    obs_rd  = uio_out;
    obs_oe  = uio_oe;
    obs_err = uo_out[1];
    obs_hi  = uo_out[7:2];
    ui_in[0] = 1'b0;
    obs_rel = 0;
    do begin
      @(negedge clk);
      obs_rel++;
    end while (uo_out[0] && obs_rel < BOUND);
    if (uo_out[0]) obs_rel = -1;
    obs_oe_after  = uio_oe;
    obs_out_after = uio_out;
  endtask

  task automatic checkTxn(input string tag, input logic rw, input logic [7:0] exp_rd,
                          input logic exp_err, input logic [63:0] exp_regs);
    checkOutput({tag, " ack_latency"}, 64'(obs_lat), 64'(SYNC + 2));
    checkOutput({tag, " rdata"}, 64'(obs_rd), 64'(rw ? exp_rd : 8'h00));
    checkOutput({tag, " oe_during_ack"}, 64'(obs_oe), 64'(rw ? 8'hFF : 8'h00));
    checkOutput({tag, " err"}, 64'(obs_err), 64'(exp_err));
    checkOutput({tag, " uo_high_bits"}, 64'(obs_hi), 64'(0));
    checkOutput({tag, " regs_before_ack"}, obs_pre, exp_regs);
    checkOutput({tag, " release_latency"}, 64'(obs_rel), 64'(SYNC + 1));
    checkOutput({tag, " oe_after_ack"}, 64'(obs_oe_after), 64'(0));
    checkOutput({tag, " out_after_ack"}, 64'(obs_out_after), 64'(0));
  endtask

  task automatic runModelTxn(input string tag, input logic rw, input logic [3:0] addr,
                             input logic [7:0] data, input logic par);
    logic [7:0] exp_rd;
    logic       exp_err;
    modelTxn(rw, addr, data, par, exp_rd, exp_err);
    applyStimulus(rw, addr, data, par);
    checkTxn(tag, rw, exp_rd, exp_err, modelRegs());
  endtask

  initial begin
    logic [7:0] exp_rd;
    logic       exp_err;
    logic       saw_ack;
    logic [7:0] d;
    int         n;

    modelClear();

    // Reset with req held high: no response until req is seen low.
    rst    = 1'b1;
    ui_in  = 8'h01;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset uo_out", 64'(uo_out), 64'(0));
    checkOutput("reset uio_oe", 64'(uio_oe), 64'(0));
    checkOutput("reset uio_out", 64'(uio_out), 64'(0));
    checkOutput("reset regs", 64'(regs_o), 64'(0));
    rst = 1'b0;
    saw_ack = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (uo_out[0]) saw_ack = 1'b1;
    end
    checkOutput("no ack with req held through reset", 64'(saw_ack), 64'(0));
    checkOutput("regs after reset release", 64'(regs_o), 64'(0));
    ui_in = 8'h00;
    repeat (4) @(negedge clk);

    // Directed vector table.
    vecs[0] = '{1'b0, 4'd3,  8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 4'd3,  8'h00, 1'b0, 8'hA5, 1'b0};
    vecs[2] = '{1'b0, 4'd12, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 4'd12, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 4'd7,  8'hC3, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 4'd7,  8'h00, 1'b0, 8'hC3, 1'b0};
    vecs[6] = '{1'b1, 4'd3,  8'h00, 1'b0, 8'hA5, 1'b0};
    vecs[7] = '{1'b1, 4'd0,  8'h00, 1'b0, 8'h00, 1'b0};
    for (int i = 0; i < 8; i++) begin
      modelTxn(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].par, exp_rd, exp_err);
      applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].par);
      checkTxn($sformatf("vec%0d", i), vecs[i].rw, vecs[i].exp_rd, vecs[i].exp_err, modelRegs());
    end
    checkOutput("reg3 holds A5", 64'(regs_o[31:24]), 64'(8'hA5));

    // Back-to-back writes then reads over the full address space.
    for (int a = 0; a < 16; a++) begin
      d = 8'(a) ^ 8'h3C;
      runModelTxn($sformatf("b2b_wr%0d", a), 1'b0, 4'(a), d, ^d);
    end
    for (int a = 0; a < 16; a++) begin
      runModelTxn($sformatf("b2b_rd%0d", a), 1'b1, 4'(a), 8'h00, 1'b0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      logic       rw;
      logic [3:0] addr;
      logic       par;
      rw   = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      d    = 8'($urandom);
`ifdef PIN_BUS_PARITY_EN
      par  = ($urandom_range(0, 3) != 0) ? ^d : ~^d;
`else
      par  = 1'($urandom_range(0, 1));
`endif
      runModelTxn($sformatf("rand%0d", k), rw, addr, d, par);
    end

`ifdef PIN_BUS_PARITY_EN
    runModelTxn("par_clear", 1'b0, 4'd5, 8'h00, 1'b0);
    applyStimulus(1'b0, 4'd5, 8'h01, 1'b0);
    checkOutput("parity bad err", 64'(obs_err), 64'(1));
    checkOutput("parity bad reg5", 64'(regs_o[47:40]), 64'(8'h00));
    applyStimulus(1'b0, 4'd5, 8'h01, 1'b1);
    checkOutput("parity good err", 64'(obs_err), 64'(0));
    checkOutput("parity good reg5", 64'(regs_o[47:40]), 64'(8'h01));
    mem[5] = 8'h01;
    applyStimulus(1'b1, 4'd5, 8'h01, 1'b0);
    checkOutput("parity read err", 64'(obs_err), 64'(0));
    checkOutput("parity read data", 64'(obs_rd), 64'(8'h01));
`endif

    // One-cycle req pulse must not disturb the register file.
    @(negedge clk);
    ui_in = {1'b0, 1'b0, 4'd1, 1'b1, 1'b1};
    @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("short pulse ack idle", 64'(uo_out[0]), 64'(0));
    checkOutput("short pulse regs", 64'(regs_o), modelRegs());
    runModelTxn("after_pulse", 1'b1, 4'd1, 8'h00, 1'b0);

    // Reset in the middle of a read's ACK phase.
    runModelTxn("pre_midread_wr", 1'b0, 4'd2, 8'h77, 1'b0);
    @(negedge clk);
    ui_in = {1'b0, 1'b0, 4'd2, 1'b1, 1'b1};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uo_out[0] && n < BOUND);
    checkOutput("midread ack seen", 64'(uo_out[0]), 64'(1));
    checkOutput("midread data", 64'(uio_out), 64'(8'h77));
    rst = 1'b1;
    #1;
    checkOutput("midread reset ack", 64'(uo_out[0]), 64'(0));
    checkOutput("midread reset oe", 64'(uio_oe), 64'(0));
    checkOutput("midread reset out", 64'(uio_out), 64'(0));
    checkOutput("midread reset regs", 64'(regs_o), 64'(0));
    modelClear();
    @(negedge clk);
    rst = 1'b0;
    saw_ack = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (uo_out[0]) saw_ack = 1'b1;
    end
    checkOutput("no ack after midread reset", 64'(saw_ack), 64'(0));
    ui_in = 8'h00;
    repeat (4) @(negedge clk);
    runModelTxn("recover_wr", 1'b0, 4'd6, 8'h96, 1'b0);
    runModelTxn("recover_rd", 1'b1, 4'd6, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
